// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe: round-robin N:1 registered mux with valid/ready; RR_MUX_PIPE_STATS_EN adds xfer_cnt
module rr_mux_pipe #(
  parameter int N = 16,
  parameter int W = 32,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
`ifdef RR_MUX_PIPE_STATS_EN
  , output logic [31:0]   xfer_cnt
`endif
);
  logic [SELW-1:0] ptr_q, ptr_d, sel_q, sel_d, grant;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d, load_en, any_v;
  assign any_v = |in_valid;
  assign load_en = !valid_q || out_ready;
  // Walk the search order backwards so the last hit is the first channel at or after ptr.
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--)
      if (in_valid[(int'(ptr_q) + k) % N]) grant = SELW'((int'(ptr_q) + k) % N);
  end
  assign in_ready = (!rst && load_en && any_v) ? (N'(1) << grant) : '0;
  always_comb begin
    data_d = data_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    valid_d = valid_q;
    if (load_en) begin
      valid_d = any_v;
      if (any_v) begin
        data_d = in_data[int'(grant)*W +: W];
        sel_d = grant;
        ptr_d = (int'(grant) == N - 1) ? '0 : SELW'(int'(grant) + 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      valid_q <= valid_d;
    end
  end
  assign out_data = data_q;
  assign out_sel = sel_q;
  assign out_valid = valid_q;
`ifdef RR_MUX_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else if (valid_q && out_ready) xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif
endmodule
